// File: rtl/xor_db_pkg.sv
// Shared definitions for the xor_db datapath primitive: default widths and
// the saturating-increment helper used by the difference counter.
package xor_db_pkg;

    localparam int XOR_DB_WIDTH_DEF = 1;
    localparam int XOR_DB_CNT_W_DEF = 8;

    // Saturating increment of a 'width'-bit value (width <= 32). The sum is
    // formed one bit wider than the counter and the carry out of bit
    // width-1 marks the all-ones case, in which the input is returned
    // unchanged so the counter holds instead of wrapping.
    function automatic logic [31:0] xor_db_sat_inc(input logic [31:0] value,
                                                   input int          width);
        logic [32:0] sum;
        logic        carry;
        sum   = {1'b0, value} + 33'd1;
        carry = ((sum >> width) & 33'd1) != 33'd0;
        if (carry) begin
            return value;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/xor_db_sat_cnt.sv
// CNT_W-bit saturating up-counter with synchronous active-high reset.
// Counts clock edges where 'inc' is high and sticks at all-ones.
// CNT_W is limited to 32 bits by the shared increment helper.
module xor_db_sat_cnt
    import xor_db_pkg::*;
#(
    parameter int CNT_W = XOR_DB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Clear on reset, otherwise step toward saturation when inc is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc) begin
            q <= CNT_W'(xor_db_sat_inc(32'(q), CNT_W));
        end
    end

endmodule

// File: rtl/xor_db.sv
// xor_db: bitwise XOR of two equal-width operands with a combinational
// result, its parity, a registered copy of the result and an optional
// saturating count of edges where the operands differ.
// Optional feature macro: XOR_DB_DIFF_CNT_EN (compiles in the counter; when
// undefined, diff_cnt is tied to zero and no counter flops exist).
module xor_db
    import xor_db_pkg::*;
#(
    parameter int WIDTH = XOR_DB_WIDTH_DEF,
    parameter int CNT_W = XOR_DB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             c_par,
    output logic [CNT_W-1:0] diff_cnt
);

    // The combinational result and its parity never depend on clk or rst,
    // and X on an operand is deliberately allowed to propagate.
    assign c     = a ^ b;
    assign c_par = ^c;

    // Registered copy of the XOR result for pipelined consumers.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
        end else begin
            c_q <= c;
        end
    end

`ifdef XOR_DB_DIFF_CNT_EN
    xor_db_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (|c),
        .q   (diff_cnt)
    );
`else
    assign diff_cnt = '0;
`endif

endmodule

// File: tb/tb_xor_db.sv
// Self-checking bench for xor_db: a WIDTH=1 instance for the combinational
// sweep and a WIDTH=4, CNT_W=2 instance driven from a vector table covering
// latency, reset, counter saturation and mid-run reset. Counter
// expectations follow the XOR_DB_DIFF_CNT_EN build setting.
module tb_xor_db;

`ifdef XOR_DB_DIFF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst1;
    logic [0:0] a1, b1, c1, c_q1;
    logic       c_par1;
    logic [7:0] diff_cnt1;

    logic       rst4;
    logic [3:0] a4, b4, c4, c_q4;
    logic       c_par4;
    logic [1:0] diff_cnt4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
    } sweep_vec_t;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       par;
        logic [3:0] cq;
        logic [1:0] cnt;
    } seq_vec_t;

    sweep_vec_t sweep[4];
    seq_vec_t   seq[13];

    xor_db #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .a        (a1),
        .b        (b1),
        .c        (c1),
        .c_q      (c_q1),
        .c_par    (c_par1),
        .diff_cnt (diff_cnt1)
    );

    xor_db #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .a        (a4),
        .b        (b4),
        .c        (c4),
        .c_q      (c_q4),
        .c_par    (c_par4),
        .diff_cnt (diff_cnt4)
    );

    // Free-running 10 ns clock shared by both instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [3:0] a_v,
                                 input logic [3:0] b_v);
        @(negedge clk);
        rst4 = rst_v;
        a4   = a_v;
        b4   = b_v;
    endtask

    initial begin
        logic [3:0] prev_cq;
        logic [1:0] exp_cnt;

        sweep[0] = '{2'b0, 2'b0, 2'b0};
        sweep[1] = '{2'b0, 2'b1, 2'b1};
        sweep[2] = '{2'b1, 2'b0, 2'b1};
        sweep[3] = '{2'b1, 2'b1, 2'b0};

        //             rst   a      b      c      par   cq     cnt
        seq[0]  = '{1'b1, 4'h1, 4'h0, 4'h1, 1'b1, 4'h0, 2'd0};
        seq[1]  = '{1'b1, 4'h1, 4'h0, 4'h1, 1'b1, 4'h0, 2'd0};
        seq[2]  = '{1'b0, 4'hA, 4'h5, 4'hF, 1'b0, 4'hF, 2'd1};
        seq[3]  = '{1'b0, 4'h3, 4'h0, 4'h3, 1'b0, 4'h3, 2'd2};
        seq[4]  = '{1'b0, 4'h1, 4'h0, 4'h1, 1'b1, 4'h1, 2'd3};
        seq[5]  = '{1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 4'hF, 2'd3};
        seq[6]  = '{1'b0, 4'h8, 4'h1, 4'h9, 1'b0, 4'h9, 2'd3};
        seq[7]  = '{1'b0, 4'h6, 4'h6, 4'h0, 1'b0, 4'h0, 2'd3};
        seq[8]  = '{1'b1, 4'hC, 4'h3, 4'hF, 1'b0, 4'h0, 2'd0};
        seq[9]  = '{1'b0, 4'h2, 4'h0, 4'h2, 1'b1, 4'h2, 2'd1};
        seq[10] = '{1'b0, 4'h4, 4'h7, 4'h3, 1'b0, 4'h3, 2'd2};
        seq[11] = '{1'b1, 4'h5, 4'h0, 4'h5, 1'b0, 4'h0, 2'd0};
        seq[12] = '{1'b0, 4'h0, 4'h4, 4'h4, 1'b1, 4'h4, 2'd1};

        rst1 = 1'b1;
        a1   = 1'b0;
        b1   = 1'b0;
        rst4 = 1'b1;
        a4   = 4'h0;
        b4   = 4'h0;

        // Combinational sweep on the 1-bit instance, paced by time only.
        for (int i = 0; i < 4; i++) begin
            a1 = sweep[i].a[0];
            b1 = sweep[i].b[0];
            #1;
            checkOutput($sformatf("sweep%0d_c", i), 32'(c1), 32'(sweep[i].c[0]));
            checkOutput($sformatf("sweep%0d_par", i), 32'(c_par1), 32'(sweep[i].c[0]));
            #9;
        end

        // One reset edge, then one differing edge on the 1-bit instance.
        @(negedge clk);
        rst1 = 1'b1;
        a1   = 1'b1;
        b1   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w1_rst_cq", 32'(c_q1), 32'd0);
        checkOutput("w1_rst_cnt", 32'(diff_cnt1), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w1_cq", 32'(c_q1), 32'd1);
        checkOutput("w1_cnt", 32'(diff_cnt1), CNT_EN ? 32'd1 : 32'd0);

        // Table-driven clocked sequence on the 4-bit instance.
        prev_cq = 4'h0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(seq[i].rst, seq[i].a, seq[i].b);
            #1;
            checkOutput($sformatf("v%0d_c_pre", i), 32'(c4), 32'(seq[i].c));
            checkOutput($sformatf("v%0d_par", i), 32'(c_par4), 32'(seq[i].par));
            if (i > 0) begin
                checkOutput($sformatf("v%0d_cq_pre", i), 32'(c_q4), 32'(prev_cq));
            end
            @(posedge clk);
            #1;
            exp_cnt = CNT_EN ? seq[i].cnt : 2'd0;
            checkOutput($sformatf("v%0d_cq", i), 32'(c_q4), 32'(seq[i].cq));
            checkOutput($sformatf("v%0d_cnt", i), 32'(diff_cnt4), 32'(exp_cnt));
            checkOutput($sformatf("v%0d_c_post", i), 32'(c4), 32'(seq[i].c));
            prev_cq = seq[i].cq;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
